// File: rtl/alu_exec_stage.sv
// Pipelined execute stage: ALU with C/Z/N flags, conditional jump resolution,
// a valid/ready output register and a DEPTH-deep result history for forwarding.
module alu_exec_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMM_W  = 8,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       op_a,
    input  logic [DATA_W-1:0]       op_b,
    input  logic [IMM_W-1:0]        imm,
    input  logic [3:0]              alu_op,
    input  logic                    alu_src,
    input  logic [1:0]              jump_type,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       result,
    output logic                    jump_taken,
    output logic [2:0]              flags,
    output logic [DEPTH*DATA_W-1:0] hist
);

    logic              out_valid_q;
    logic [DATA_W-1:0] result_q;
    logic              jump_q;
    logic              c_q, z_q, n_q;
    logic [DATA_W-1:0] hist_q [DEPTH];

    logic              accept;
    logic [DATA_W-1:0] b_opnd;
    logic [DATA_W-1:0] res_d;
    logic              c_d, z_d, n_d, jump_d;
    logic              upd_zn;
    logic              amt_zero, amt_big;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   shl_ext;
    logic [DATA_W:0]   shr_ext;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        b_opnd   = alu_src ? DATA_W'(imm) : op_b;
        amt_zero = (imm == '0);
        amt_big  = 32'(imm) > DATA_W;
        // The extra bit catches the last bit shifted out (carry).
        shl_ext  = {1'b0, op_a} << imm;
        shr_ext  = {op_a, 1'b0} >> imm;
        sum      = '0;
        jump_d   = (jump_type == 2'd1 && z_q) || (jump_type == 2'd2 && n_q) ||
                   (jump_type == 2'd3 && c_q);
        c_d      = c_q;
        z_d      = z_q;
        n_d      = n_q;
        // Taken jump clears the tested flag; the op's own flag write below overrides it.
        if (jump_d) begin
            case (jump_type)
                2'd1:    z_d = 1'b0;
                2'd2:    n_d = 1'b0;
                2'd3:    c_d = 1'b0;
                default: ;
            endcase
        end
        res_d  = op_a;
        upd_zn = 1'b0;
        case (alu_op)
            4'd1: begin
                res_d  = ~op_a;
                upd_zn = 1'b1;
            end
            4'd2: begin
                sum    = {1'b0, op_a} + (DATA_W + 1)'(1);
                res_d  = sum[DATA_W-1:0];
                c_d    = sum[DATA_W];
                upd_zn = 1'b1;
            end
            4'd3: begin
                res_d  = op_a - DATA_W'(1);
                c_d    = (op_a == '0);
                upd_zn = 1'b1;
            end
            4'd4: begin
                sum    = {1'b0, op_a} + {1'b0, b_opnd};
                res_d  = sum[DATA_W-1:0];
                c_d    = sum[DATA_W];
                upd_zn = 1'b1;
            end
            4'd5: begin
                res_d  = op_a - b_opnd;
                c_d    = (op_a < b_opnd);
                upd_zn = 1'b1;
            end
            4'd6: begin
                res_d  = op_a & b_opnd;
                upd_zn = 1'b1;
            end
            4'd7: begin
                res_d  = op_a | b_opnd;
                upd_zn = 1'b1;
            end
            4'd8: begin
                upd_zn = 1'b1;
                if (amt_big) begin
                    res_d = '0;
                    c_d   = 1'b0;
                end else if (!amt_zero) begin
                    res_d = shl_ext[DATA_W-1:0];
                    c_d   = shl_ext[DATA_W];
                end
            end
            4'd9: begin
                upd_zn = 1'b1;
                if (amt_big) begin
                    res_d = '0;
                    c_d   = 1'b0;
                end else if (!amt_zero) begin
                    res_d = shr_ext[DATA_W:1];
                    c_d   = shr_ext[0];
                end
            end
            4'd10:   res_d = b_opnd;
            4'd11:   c_d = 1'b1;
            4'd12:   c_d = 1'b0;
            default: ;
        endcase
        if (upd_zn) begin
            z_d = (res_d == '0);
            n_d = res_d[DATA_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            jump_q      <= 1'b0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
        end else begin
            if (flush)          out_valid_q <= 1'b0;
            else if (accept)    out_valid_q <= 1'b1;
            else if (out_ready) out_valid_q <= 1'b0;
            if (accept) begin
                result_q <= res_d;
                jump_q   <= jump_d;
                c_q      <= c_d;
                z_q      <= z_d;
                n_q      <= n_d;
                for (int i = DEPTH - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
                hist_q[0] <= res_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign jump_taken = jump_q;
    assign flags      = {c_q, z_q, n_q};

    for (genvar g = 0; g < DEPTH; g++) begin : g_hist
        assign hist[g*DATA_W +: DATA_W] = hist_q[g];
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage (DATA_W=16, IMM_W=8, DEPTH=3).
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] op_a, op_b;
    logic [7:0]  imm;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [1:0]  jump_type;
    logic        flush;
    logic        out_valid, out_ready;
    logic [15:0] result;
    logic        jump_taken;
    logic [2:0]  flags;
    logic [47:0] hist;

    alu_exec_stage #(.DATA_W(16), .IMM_W(8), .DEPTH(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .imm(imm), .alu_op(alu_op), .alu_src(alu_src),
        .jump_type(jump_type), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .jump_taken(jump_taken),
        .flags(flags), .hist(hist)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic        jt;
        logic [2:0]  fl;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [2:0]  m_fl;
    logic [15:0] m_hist [3];
    int          checks = 0;
    int          errors = 0;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] rb,
                                   input logic [7:0] im, input logic [3:0] op,
                                   input logic src, input logic [1:0] jt);
        exp_t        x;
        logic        c, z, n, j, zn;
        logic [15:0] b, r;
        logic [16:0] s;
        {c, z, n} = m_fl;
        j = (jt == 2'd1 && z) || (jt == 2'd2 && n) || (jt == 2'd3 && c);
        if (j) begin
            if (jt == 2'd1) z = 1'b0;
            else if (jt == 2'd2) n = 1'b0;
            else c = 1'b0;
        end
        b  = src ? {8'h00, im} : rb;
        r  = a;
        zn = 1'b0;
        case (op)
            4'd1: begin r = ~a; zn = 1'b1; end
            4'd2: begin s = {1'b0, a} + 17'd1; r = s[15:0]; c = s[16]; zn = 1'b1; end
            4'd3: begin r = a - 16'd1; c = (a == 16'd0); zn = 1'b1; end
            4'd4: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; zn = 1'b1; end
            4'd5: begin r = a - b; c = (a < b); zn = 1'b1; end
            4'd6: begin r = a & b; zn = 1'b1; end
            4'd7: begin r = a | b; zn = 1'b1; end
            4'd8: begin
                zn = 1'b1;
                if (im > 8'd16) begin r = 16'd0; c = 1'b0; end
                else for (int i = 0; i < int'(im); i++) begin c = r[15]; r = {r[14:0], 1'b0}; end
            end
            4'd9: begin
                zn = 1'b1;
                if (im > 8'd16) begin r = 16'd0; c = 1'b0; end
                else for (int i = 0; i < int'(im); i++) begin c = r[0]; r = {1'b0, r[15:1]}; end
            end
            4'd10: r = b;
            4'd11: c = 1'b1;
            4'd12: c = 1'b0;
            default: ;
        endcase
        if (zn) begin
            z = (r == 16'd0);
            n = r[15];
        end
        m_fl      = {c, z, n};
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = r;
        x.res = r;
        x.jt  = j;
        x.fl  = m_fl;
        return x;
    endfunction

    function automatic void model_reset();
        m_fl = 3'b000;
        for (int i = 0; i < 3; i++) m_hist[i] = 16'd0;
        sb.delete();
    endfunction

    // Offer one op for one cycle; expected entry is pushed only if it is accepted.
    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [7:0] im,
                         input logic [3:0] op, input logic src, input logic [1:0] jt);
        op_a = a; op_b = b; imm = im; alu_op = op; alu_src = src; jump_type = jt;
        in_valid = 1'b1;
        #1;
        if (in_ready && !flush && !rst) sb.push_back(model(a, b, im, op, src, jt));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        drive(16'hFFFF, 16'h0001, 8'h00, 4'd4, 1'b0, 2'd0);
        rst = 1'b0;
        model_reset();
        checks++;
        if ({out_valid, result, jump_taken, flags, hist} !== '0) begin
            errors++;
            $display("FAIL reset: v=%b res=%h j=%b fl=%b hist=%h, want all 0",
                     out_valid, result, jump_taken, flags, hist);
        end
    endtask

    task automatic test_add_carry();
        out_ready = 1'b1;
        drive(16'hFFFF, 16'h0001, 8'h00, 4'd4, 1'b0, 2'd0);
        checks++;
        e = sb.pop_front();
        if ({out_valid, result, jump_taken, flags} !== {1'b1, e.res, e.jt, e.fl}) begin
            errors++;
            $display("FAIL add_sb: got v=%b res=%h j=%b fl=%b want v=1 res=%h j=%b fl=%b",
                     out_valid, result, jump_taken, flags, e.res, e.jt, e.fl);
        end
        checks++;
        if ({result, flags} !== {16'h0000, 3'b110}) begin
            errors++;
            $display("FAIL add_const: got res=%h fl=%b want res=0000 fl=110", result, flags);
        end
    endtask

    task automatic test_sub_jump();
        out_ready = 1'b1;
        drive(16'd5, 16'd7, 8'h00, 4'd5, 1'b0, 2'd0);
        checks++;
        e = sb.pop_front();
        if ({out_valid, result, jump_taken, flags} !== {1'b1, e.res, e.jt, e.fl} ||
            {result, flags} !== {16'hFFFE, 3'b101}) begin
            errors++;
            $display("FAIL sub: got res=%h fl=%b want res=%h fl=%b (fffe/101)",
                     result, flags, e.res, e.fl);
        end
        drive(16'h1234, 16'h0000, 8'h00, 4'd0, 1'b0, 2'd3);
        checks++;
        e = sb.pop_front();
        if ({out_valid, result, jump_taken, flags} !== {1'b1, e.res, e.jt, e.fl} ||
            {jump_taken, flags} !== {1'b1, 3'b001}) begin
            errors++;
            $display("FAIL jump_c: got res=%h j=%b fl=%b want res=%h j=1 fl=001",
                     result, jump_taken, flags, e.res);
        end
    endtask

    task automatic test_shift();
        logic [15:0] a_t [4] = '{16'h8001, 16'h0000, 16'h1234, 16'h8001};
        logic [7:0]  i_t [4] = '{8'd1, 8'd0, 8'd20, 8'd1};
        logic [3:0]  o_t [4] = '{4'd8, 4'd8, 4'd8, 4'd9};
        logic [18:0] w_t [4] = '{{16'h0002, 3'b100}, {16'h0000, 3'b110},
                                 {16'h0000, 3'b010}, {16'h4000, 3'b100}};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(a_t[k], 16'hFFFF, i_t[k], o_t[k], 1'b1, 2'd0);
            checks++;
            e = sb.pop_front();
            if ({out_valid, result, jump_taken, flags} !== {1'b1, e.res, e.jt, e.fl} ||
                {result, flags} !== w_t[k]) begin
                errors++;
                $display("FAIL shift%0d: got res=%h fl=%b want res=%h fl=%b",
                         k, result, flags, w_t[k][18:3], w_t[k][2:0]);
            end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        drive(16'd3, 16'd4, 8'h00, 4'd4, 1'b0, 2'd0);
        checks++;
        e = sb.pop_front();
        if ({out_valid, result, flags} !== {1'b1, 16'd7, e.fl}) begin
            errors++;
            $display("FAIL stall_first: got v=%b res=%h want v=1 res=0007", out_valid, result);
        end
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready: got in_ready=%b want 0", in_ready);
        end
        drive(16'h0000, 16'h0055, 8'h00, 4'd10, 1'b0, 2'd0);
        checks++;
        if ({out_valid, result, sb.size() == 0} !== {1'b1, 16'd7, 1'b1}) begin
            errors++;
            $display("FAIL stall_hold: got v=%b res=%h pending=%0d want v=1 res=0007 pending=0",
                     out_valid, result, sb.size());
        end
        out_ready = 1'b1;
        drive(16'h0000, 16'h0055, 8'h00, 4'd10, 1'b0, 2'd0);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL stall_release: second op not accepted, got 0 want 1 entry");
        end else begin
            e = sb.pop_front();
            if ({out_valid, result, jump_taken, flags} !== {1'b1, 16'h0055, e.jt, e.fl}) begin
                errors++;
                $display("FAIL stall_release: got v=%b res=%h fl=%b want v=1 res=0055 fl=%b",
                         out_valid, result, flags, e.fl);
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        drive(16'h00AA, 16'h0000, 8'h00, 4'd0, 1'b0, 2'd0);
        void'(sb.pop_front());
        flush = 1'b1;
        drive(16'hFFFF, 16'h0001, 8'h00, 4'd4, 1'b0, 2'd0);
        flush = 1'b0;
        checks++;
        if ({out_valid, flags, hist} !== {1'b0, m_fl, m_hist[2], m_hist[1], m_hist[0]}) begin
            errors++;
            $display("FAIL flush: got v=%b fl=%b hist=%h want v=0 fl=%b hist=%h",
                     out_valid, flags, hist, m_fl, {m_hist[2], m_hist[1], m_hist[0]});
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            drive(16'($urandom), 16'($urandom), 8'($urandom_range(0, 24)),
                  4'($urandom_range(0, 15)), 1'($urandom), 2'($urandom));
            checks++;
            e = sb.pop_front();
            if ({out_valid, result, jump_taken, flags, hist} !==
                {1'b1, e.res, e.jt, e.fl, m_hist[2], m_hist[1], m_hist[0]}) begin
                errors++;
                $display("FAIL b2b%0d: got res=%h j=%b fl=%b hist=%h want res=%h j=%b fl=%b hist=%h",
                         k, result, jump_taken, flags, hist, e.res, e.jt, e.fl,
                         {m_hist[2], m_hist[1], m_hist[0]});
            end
        end
    endtask

    task automatic test_history();
        test_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            drive(16'(k), 16'h0000, 8'h00, 4'd0, 1'b0, 2'd0);
            void'(sb.pop_front());
        end
        checks++;
        if (hist !== {16'd2, 16'd3, 16'd4}) begin
            errors++;
            $display("FAIL hist: got %h want 000200030004", hist);
        end
        rst = 1'b1;
        drive(16'h0009, 16'h0000, 8'h00, 4'd1, 1'b0, 2'd0);
        rst = 1'b0;
        model_reset();
        checks++;
        if ({out_valid, result, jump_taken, flags, hist} !== '0) begin
            errors++;
            $display("FAIL mid_reset: v=%b res=%h j=%b fl=%b hist=%h, want all 0",
                     out_valid, result, jump_taken, flags, hist);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; imm = '0; alu_op = '0;
        alu_src = 1'b0; jump_type = '0; flush = 1'b0; out_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_add_carry();
        test_sub_jump();
        test_shift();
        test_stall();
        test_flush();
        test_back_to_back();
        test_history();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
